// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared VGA pipeline constants, blink state encoding and a
//             rectangle-membership helper.
//  Contents : RGB_W, CNT_W, CHAR_W, CHAR_H, TEXT_COLS, TEXT_ROWS,
//             blink_state_t, in_rect().
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int RGB_W     = 12;
    localparam int CNT_W     = 11;
    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 16;

    typedef enum logic [0:0] {
        VIS = 1'b0,
        HID = 1'b1
    } blink_state_t;

    // Full-width comparison on CNT_W+1 bits, so a position left of or above
    // the rectangle can never wrap around into it.
    function automatic logic in_rect(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] y,
        input logic [CNT_W-1:0] x0,
        input logic [CNT_W-1:0] y0,
        input logic [CNT_W:0]   w,
        input logic [CNT_W:0]   h
    );
        logic [CNT_W:0] x_end;
        logic [CNT_W:0] y_end;
        x_end = {1'b0, x0} + w;
        y_end = {1'b0, y0} + h;
        return ({1'b0, x} >= {1'b0, x0}) && ({1'b0, x} < x_end) &&
               ({1'b0, y} >= {1'b0, y0}) && ({1'b0, y} < y_end);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// ============================================================================
//  Module   : delay
//  Purpose  : Fixed-depth register chain; reset clears every stage.
//  Ports    : clk, rst (sync, active-high), din[WIDTH], dout[WIDTH]
//  Revision : 1.0 - initial release
// ============================================================================
module delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        r_pipe[0] <= rst ? '0 : din;
    end

    generate
        for (genvar g = 1; g < DEPTH; g++) begin : g_stage
            always_ff @(posedge clk) begin
                r_pipe[g] <= rst ? '0 : r_pipe[g-1];
            end
        end
    endgenerate

    assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/draw_char_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : draw_char_overlay
//  Purpose  : Paints a 16x16 character text box (8x16 px glyphs) over the RGB
//             stream, with optional whole-box blinking. Latency 4 clocks.
//  Ports    : clk, rst, en, blink, {h,v}count_in, {h,v}sync_in,
//             {h,v}blnk_in, rgb_in -> char_yx, char_line (to char/font ROMs)
//             char_pixels (from font ROM, 2 clocks after the address)
//             {h,v}count_out, {h,v}sync_out, {h,v}blnk_out, rgb_out
//  Revision : 1.0 - initial release
// ============================================================================
module draw_char_overlay
    import vga_pkg::*;
#(
    parameter int               XPOS         = 256,
    parameter int               YPOS         = 200,
    parameter logic [RGB_W-1:0] TEXT_RGB     = 12'hFF0,
    parameter int               BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              blink,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic [7:0]        char_yx,
    output logic [3:0]        char_line,
    input  logic [7:0]        char_pixels,
    output logic [CNT_W-1:0]  hcount_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    localparam logic [CNT_W-1:0] C_XPOS  = CNT_W'(XPOS);
    localparam logic [CNT_W-1:0] C_YPOS  = CNT_W'(YPOS);
    localparam logic [CNT_W:0]   C_BOX_W = (CNT_W+1)'(TEXT_COLS * CHAR_W);
    localparam logic [CNT_W:0]   C_BOX_H = (CNT_W+1)'(TEXT_ROWS * CHAR_H);
    localparam logic [5:0]       C_LAST  = 6'(BLINK_FRAMES - 1);
    localparam int               C_SB_W  = 2*CNT_W + 4 + RGB_W + 1 + 3;

    // ---------------- position decode ----------------
    // Only the low bits of the relative coordinates are needed; the low bits
    // of a difference depend only on the low bits of its operands.
    logic       w_in_box;
    logic [6:0] w_rx;
    logic [7:0] w_ry;

    assign w_in_box = in_rect(hcount_in, vcount_in, C_XPOS, C_YPOS, C_BOX_W, C_BOX_H);
    assign w_rx     = hcount_in[6:0] - C_XPOS[6:0];
    assign w_ry     = vcount_in[7:0] - C_YPOS[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            char_yx   <= '0;
            char_line <= '0;
        end else if (w_in_box) begin
            char_yx   <= {w_ry[7:4], w_rx[6:3]};
            char_line <= w_ry[3:0];
        end else begin
            char_yx   <= '0;
            char_line <= '0;
        end
    end

    // ---------------- sideband delay (matches address + 2 ROM stages) ----------------
    logic [C_SB_W-1:0] w_sb_in;
    logic [C_SB_W-1:0] w_sb_out;
    logic [CNT_W-1:0]  w_d_hcount;
    logic [CNT_W-1:0]  w_d_vcount;
    logic              w_d_hsync;
    logic              w_d_vsync;
    logic              w_d_hblnk;
    logic              w_d_vblnk;
    logic [RGB_W-1:0]  w_d_rgb;
    logic              w_d_in_box;
    logic [2:0]        w_d_rx;

    assign w_sb_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                      rgb_in, w_in_box, w_rx[2:0]};

    delay #(
        .WIDTH (C_SB_W),
        .DEPTH (3)
    ) u_sideband (
        .clk  (clk),
        .rst  (rst),
        .din  (w_sb_in),
        .dout (w_sb_out)
    );

    assign {w_d_hcount, w_d_vcount, w_d_hsync, w_d_vsync, w_d_hblnk, w_d_vblnk,
            w_d_rgb, w_d_in_box, w_d_rx} = w_sb_out;

    // ---------------- blink FSM ----------------
    blink_state_t r_state;
    blink_state_t w_state_next;
    logic [5:0]   r_frame_cnt;
    logic [5:0]   w_frame_cnt_next;
    logic         r_vblnk_prev;
    logic         w_tick;
    logic         w_visible;

    assign w_tick    = vblnk_in & ~r_vblnk_prev;
    assign w_visible = (r_state == VIS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= VIS;
            r_frame_cnt  <= '0;
            r_vblnk_prev <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_vblnk_prev <= vblnk_in;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        if (!en || !blink) begin
            w_state_next     = VIS;
            w_frame_cnt_next = '0;
        end else if (w_tick) begin
            if (r_frame_cnt == C_LAST) begin
                w_frame_cnt_next = '0;
                w_state_next     = (r_state == VIS) ? HID : VIS;
            end else begin
                w_frame_cnt_next = r_frame_cnt + 6'd1;
            end
        end
    end

    // ---------------- output register ----------------
    logic w_glyph;
    assign w_glyph = char_pixels[3'd7 - w_d_rx];

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= w_d_hcount;
            vcount_out <= w_d_vcount;
            hsync_out  <= w_d_hsync;
            vsync_out  <= w_d_vsync;
            hblnk_out  <= w_d_hblnk;
            vblnk_out  <= w_d_vblnk;
            if (w_d_hblnk || w_d_vblnk)
                rgb_out <= '0;
            else if (en && w_visible && w_d_in_box && w_glyph)
                rgb_out <= TEXT_RGB;
            else
                rgb_out <= w_d_rgb;
        end
    end

endmodule
`default_nettype wire
